// File: rtl/mux_eval_pkg.sv
// Shared types and constants for the mux fitness evaluator and its golden model.
package mux_eval_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } eval_state_e;

    localparam int unsigned SettleW = 8;

    // Total candidate input count: 2**n_sel data inputs plus n_sel select inputs.
    function automatic int unsigned calc_n_in(input int unsigned n_sel);
        return (32'd1 << n_sel) + n_sel;
    endfunction

endpackage

// File: rtl/mux_golden_model.sv
// Combinational reference N:1 mux: data in vec[N_DATA-1:0], select in vec[N_IN-1:N_DATA].
module mux_golden_model
    import mux_eval_pkg::*;
#(
    parameter int unsigned N_SEL = 1,
    localparam int unsigned N_DATA = 1 << N_SEL,
    localparam int unsigned N_IN = calc_n_in(N_SEL)
) (
    input  logic [N_IN-1:0] vec,
    output logic            expected
);

    logic [N_DATA-1:0] data;
    logic [N_SEL-1:0]  sel;

    assign data     = vec[N_DATA-1:0];
    assign sel      = vec[N_IN-1:N_DATA];
    assign expected = data[sel];

endmodule

// File: rtl/mux_fitness_evaluator.sv
// Exhaustively drives a candidate N:1 mux and scores it against the golden mux.
// Optional MUX_EVAL_FAIL_CAPTURE_EN adds capture of the first mismatching vector.
module mux_fitness_evaluator
    import mux_eval_pkg::*;
#(
    parameter int unsigned N_SEL = 1,
    parameter int unsigned SETTLE_CYCLES = 2,
    localparam int unsigned N_IN = calc_n_in(N_SEL)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] vec_out,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [N_IN:0]   score,
    output logic            perfect
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
    ,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
`endif
);

    localparam int unsigned VECS = 1 << N_IN;
    localparam int unsigned ScoreW = N_IN + 1;
    localparam logic [ScoreW-1:0] VecsScore = ScoreW'(VECS);
    localparam logic [N_IN-1:0] VecLast = {N_IN{1'b1}};
    localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

    eval_state_e        state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [SettleW-1:0] settle_q, settle_d;
    logic [N_IN:0]      score_q, score_d;
    logic               perfect_q, perfect_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               expected;
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
    logic [N_IN-1:0]    ff_vec_q, ff_vec_d;
    logic               ff_valid_q, ff_valid_d;
`endif

    mux_golden_model #(
        .N_SEL (N_SEL)
    ) u_golden (
        .vec      (vec_q),
        .expected (expected)
    );

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        settle_d  = settle_q;
        score_d   = score_q;
        perfect_d = perfect_q;
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
        ff_vec_d   = ff_vec_q;
        ff_valid_d = ff_valid_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    vec_d     = '0;
                    settle_d  = '0;
                    score_d   = '0;
                    perfect_d = 1'b0;
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
                    ff_vec_d   = '0;
                    ff_valid_d = 1'b0;
`endif
                    state_d   = StDrive;
                end
            end
            StDrive: begin
                if (settle_q == SettleLast) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            StSample: begin
                if (dut_out == expected) begin
                    score_d = score_q + 1'b1;
                end
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
                else if (!ff_valid_q) begin
                    ff_vec_d   = vec_q;
                    ff_valid_d = 1'b1;
                end
`endif
                // Final vector: hold vec_out rather than wrapping to zero.
                if (vec_q == VecLast) begin
                    state_d = StDone;
                end else begin
                    vec_d    = vec_q + 1'b1;
                    settle_d = '0;
                    state_d  = StDrive;
                end
            end
            StDone: begin
                perfect_d = (score_q == VecsScore);
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs lag the state by one cycle so done and perfect appear together.
    assign busy_d = (state_q != StIdle);
    assign done_d = (state_q == StDone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            vec_q     <= '0;
            settle_q  <= '0;
            score_q   <= '0;
            perfect_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            score_q   <= score_d;
            perfect_q <= perfect_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef MUX_EVAL_FAIL_CAPTURE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_vec_q   <= '0;
            ff_valid_q <= 1'b0;
        end else begin
            ff_vec_q   <= ff_vec_d;
            ff_valid_q <= ff_valid_d;
        end
    end

    assign first_fail_vec   = ff_vec_q;
    assign first_fail_valid = ff_valid_q;
`endif

    assign vec_out = vec_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign score   = score_q;
    assign perfect = perfect_q;

endmodule

// File: tb/tb_mux_fitness_evaluator.sv
// Directed bench for mux_fitness_evaluator with N_SEL=1, SETTLE_CYCLES=2.
module tb_mux_fitness_evaluator;

    localparam int unsigned N_IN = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            dut_out;
    logic [N_IN-1:0] vec_out;
    logic            busy;
    logic            done;
    logic [N_IN:0]   score;
    logic            perfect;
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
    logic [N_IN-1:0] first_fail_vec;
    logic            first_fail_valid;
`endif

    int errors = 0;
    int checks = 0;
    // Candidate behaviour: 0 correct mux, 1 stuck-at-0, 2 inverted mux, 3 passes I0 only.
    int mode = 0;

    always #5 clk = ~clk;

    always_comb begin
        dut_out = 1'b0;
        case (mode)
            0: dut_out = vec_out[2] ? vec_out[1] : vec_out[0];
            1: dut_out = 1'b0;
            2: dut_out = ~(vec_out[2] ? vec_out[1] : vec_out[0]);
            3: dut_out = vec_out[0];
            default: dut_out = 1'b0;
        endcase
    end

    mux_fitness_evaluator #(
        .N_SEL         (1),
        .SETTLE_CYCLES (2)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .vec_out          (vec_out),
        .dut_out          (dut_out),
        .busy             (busy),
        .done             (done),
        .score            (score),
        .perfect          (perfect)
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
        ,
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One evaluation: pulse start, then watch 40 cycles. poke_at re-pulses start mid-run.
    task automatic run_eval(input int m, input int poke_at,
                            output int lat, output int busy_n, output int done_n,
                            output int vec3);
        mode = m;
        lat = 0;
        busy_n = 0;
        done_n = 0;
        vec3 = -1;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == poke_at) start = 1'b1;
            if (c == poke_at + 1) start = 1'b0;
            if (c == 3) vec3 = int'(vec_out);
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (lat == 0) lat = c;
            end
        end
    endtask

    initial begin
        int lat, bn, dn, v3;
        rst_n = 1'b0;
        start = 1'b0;
        #12;
        check("rst_vec", 32'(vec_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_score", 32'(score), 0);
        check("rst_perfect", 32'(perfect), 0);
        @(negedge clk) rst_n = 1'b1;

        // Correct mux: full score, 25-cycle latency, busy for 25 cycles.
        run_eval(0, -1, lat, bn, dn, v3);
        check("ok_latency", 32'(lat), 25);
        check("ok_busy_cycles", 32'(bn), 25);
        check("ok_done_pulses", 32'(dn), 1);
        check("ok_vec_at_c3", 32'(v3), 1);
        check("ok_score", 32'(score), 8);
        check("ok_perfect", 32'(perfect), 1);
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
        check("ok_ff_valid", 32'(first_fail_valid), 0);
`endif

        run_eval(1, -1, lat, bn, dn, v3);
        check("stuck0_score", 32'(score), 4);
        check("stuck0_perfect", 32'(perfect), 0);

        run_eval(2, -1, lat, bn, dn, v3);
        check("inv_score", 32'(score), 0);
        check("inv_perfect", 32'(perfect), 0);

        run_eval(3, -1, lat, bn, dn, v3);
        check("i0_score", 32'(score), 6);
`ifdef MUX_EVAL_FAIL_CAPTURE_EN
        check("i0_ff_vec", 32'(first_fail_vec), 5);
        check("i0_ff_valid", 32'(first_fail_valid), 1);
`endif

        // Start pulsed while busy is ignored.
        run_eval(0, 10, lat, bn, dn, v3);
        check("poke_latency", 32'(lat), 25);
        check("poke_done_pulses", 32'(dn), 1);
        check("poke_score", 32'(score), 8);

        // Asynchronous abort mid-DRIVE.
        mode = 0;
        dn = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_vec", 32'(vec_out), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_score", 32'(score), 0);
        check("abort_done", 32'(done), 0);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check("abort_no_done", 32'(dn), 0);
        @(negedge clk) rst_n = 1'b1;
        run_eval(0, -1, lat, bn, dn, v3);
        check("after_abort_score", 32'(score), 8);
        check("after_abort_latency", 32'(lat), 25);

        // Start held high: back-to-back runs with a one-cycle idle gap.
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 51; c++) begin
            @(posedge clk);
            #1;
            if (c == 25) begin
                check("b2b_done1", 32'(done), 1);
                check("b2b_score1", 32'(score), 8);
            end
            if (c == 26) begin
                check("b2b_gap_busy", 32'(busy), 0);
                check("b2b_score_cleared", 32'(score), 0);
            end
            if (c == 51) begin
                check("b2b_done2", 32'(done), 1);
                check("b2b_score2", 32'(score), 8);
                start = 1'b0;
            end
        end
        repeat (5) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
